// File: rtl/fifo_control_unit_pkg.sv
// Shared definitions for the FIFO control end.
// Contents:
//   STK_HEIGHT_DEF / STK_PTR_WIDTH_DEF  default stack depth and pointer width
//   stk_op_e                            per-cycle accepted operation {read, write}
//   ptr_inc()                           wrapping pointer increment for any depth >= 2
package fifo_control_unit_pkg;

  localparam int unsigned STK_HEIGHT_DEF    = 8;
  localparam int unsigned STK_PTR_WIDTH_DEF = 3;

  // Encoding is {read accepted, write accepted} so it can be built by concatenation.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } stk_op_e;

  // Wraps at the stack height rather than at a power of two, so non-power-of-2
  // depths never address a word beyond the last datapath entry.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned h);
    return (p == h - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_control_unit_if.sv
// Handshake/status bundle between the producer/consumer side and the FIFO control unit.
// Signals:
//   write_req, read_req          requests from producer / consumer
//   write_to_stk, read_fr_stk    accepted push / pop (datapath write / read enables)
//   write_ptr, read_ptr          datapath addresses
//   stk_full, stk_empty          occupancy flags
//   stk_count                    words currently held
//   data_valid                   datapath data_out holds a popped word this cycle
//   overflow_err, underflow_err  1-cycle pulses for a rejected request in the previous cycle
// Modports: master = requester side, slave = control unit.
interface fifo_control_unit_if
  import fifo_control_unit_pkg::*;
#(
  parameter int unsigned stk_ptr_width = STK_PTR_WIDTH_DEF
);

  logic                     write_req;
  logic                     read_req;
  logic                     write_to_stk;
  logic                     read_fr_stk;
  logic [stk_ptr_width-1:0] write_ptr;
  logic [stk_ptr_width-1:0] read_ptr;
  logic                     stk_full;
  logic                     stk_empty;
  logic [stk_ptr_width:0]   stk_count;
  logic                     data_valid;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output write_req, read_req,
    input  write_to_stk, read_fr_stk, write_ptr, read_ptr,
    input  stk_full, stk_empty, stk_count, data_valid, overflow_err, underflow_err
  );

  modport slave (
    input  write_req, read_req,
    output write_to_stk, read_fr_stk, write_ptr, read_ptr,
    output stk_full, stk_empty, stk_count, data_valid, overflow_err, underflow_err
  );

endinterface

// File: rtl/fifo_control_unit_ptr_counter.sv
// Wrapping address counter for one side (write or read) of the stack.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset, clears ptr to 0
//   inc  in   advance the pointer this cycle (an accepted operation)
//   ptr  out  registered address, wraps from stk_height-1 to 0
module fifo_control_unit_ptr_counter
  import fifo_control_unit_pkg::*;
#(
  parameter int unsigned stk_height    = STK_HEIGHT_DEF,
  parameter int unsigned stk_ptr_width = STK_PTR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [stk_ptr_width-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= stk_ptr_width'(ptr_inc(32'(ptr), stk_height));
    end
  end

endmodule

// File: rtl/fifo_control_unit.sv
// Single-clock control end of the FIFO: arbitrates push/pop requests, owns the
// write/read pointers and the occupancy count, and produces the datapath enables,
// occupancy flags, data_valid and the rejected-request error pulses.
// Ports:
//   clk  in     single clock, rising edge
//   rst  in     asynchronous active-low reset
//   ctl  slave  fifo_control_unit_if bundle (requests in; enables, pointers,
//               count, flags, data_valid, error pulses out)
module fifo_control_unit
  import fifo_control_unit_pkg::*;
#(
  parameter int unsigned stk_height    = STK_HEIGHT_DEF,
  parameter int unsigned stk_ptr_width = STK_PTR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_control_unit_if.slave   ctl
);

  localparam logic [stk_ptr_width:0] CNT_ONE  = {{stk_ptr_width{1'b0}}, 1'b1};
  localparam logic [stk_ptr_width:0] CNT_FULL = (stk_ptr_width+1)'(stk_height);

  logic                   read_acc;
  logic                   write_acc;
  stk_op_e                op;
  logic [stk_ptr_width:0] count_nxt;

  // A pop is honoured whenever a word is held. A push into a full stack is still
  // honoured when a pop frees the slot on the same edge; on an empty stack the pop
  // is refused even with a concurrent push (no fall-through).
  assign read_acc  = ctl.read_req & ~ctl.stk_empty;
  assign write_acc = ctl.write_req & (~ctl.stk_full | read_acc);

  assign ctl.read_fr_stk  = read_acc;
  assign ctl.write_to_stk = write_acc;

  assign op = stk_op_e'({read_acc, write_acc});

  always_comb begin
    count_nxt = ctl.stk_count;
    unique case (op)
      OP_WRITE: count_nxt = ctl.stk_count + CNT_ONE;
      OP_READ:  count_nxt = ctl.stk_count - CNT_ONE;
      default:  count_nxt = ctl.stk_count;
    endcase
  end

  fifo_control_unit_ptr_counter #(
    .stk_height    (stk_height),
    .stk_ptr_width (stk_ptr_width)
  ) u_write_ptr (
    .clk (clk),
    .rst (rst),
    .inc (write_acc),
    .ptr (ctl.write_ptr)
  );

  fifo_control_unit_ptr_counter #(
    .stk_height    (stk_height),
    .stk_ptr_width (stk_ptr_width)
  ) u_read_ptr (
    .clk (clk),
    .rst (rst),
    .inc (read_acc),
    .ptr (ctl.read_ptr)
  );

  // Flags are derived from the next-state count so they line up with the count
  // register instead of trailing it by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl.stk_count <= '0;
      ctl.stk_empty <= 1'b1;
      ctl.stk_full  <= 1'b0;
    end else begin
      ctl.stk_count <= count_nxt;
      ctl.stk_empty <= (count_nxt == '0);
      ctl.stk_full  <= (count_nxt == CNT_FULL);
    end
  end

  // data_valid tracks the datapath's one-cycle registered read; the error pulses
  // report a rejected request one cycle later and never stick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl.data_valid    <= 1'b0;
      ctl.overflow_err  <= 1'b0;
      ctl.underflow_err <= 1'b0;
    end else begin
      ctl.data_valid    <= read_acc;
      ctl.overflow_err  <= ctl.write_req & ~write_acc;
      ctl.underflow_err <= ctl.read_req & ~read_acc;
    end
  end

endmodule
